// File: rtl/axis_ctr_rx_checker.sv
// AXI-Stream counter-stream sink: checks each accepted beat against a tracked expected value,
// throttles tready with a 16-bit Galois LFSR. Optional macro AXIS_CTR_RX_RESYNC_EN re-aligns on mismatch.
module axis_ctr_rx_checker #(
  parameter int          byte_width = 4,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tvalid,
  output logic                    tready,
  input  logic [8*byte_width-1:0] tdata,
  input  logic                    tlast,
  input  logic                    throttle_en,
  input  logic                    clear_stats,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic                    err_sticky,
  output logic                    tlast_err,
  output logic [8*byte_width-1:0] err_expected,
  output logic [8*byte_width-1:0] err_actual
);

  localparam int                   DW        = 8 * byte_width;
  localparam logic [15:0]          LFSR_TAPS = 16'hB400;
  localparam logic [DW-1:0]        DATA_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [DW-1:0] expected;
  logic [DW-1:0] expected_next;
  logic          accept;
  logic          mismatch;

  // Handshake: a beat transfers at a rising edge where tvalid && tready are both high;
  // tready is registered and may fall while tvalid is held, which is legal for a slave.
  assign accept   = tvalid && tready;
  assign mismatch = accept && (tdata != expected);

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

`ifdef AXIS_CTR_RX_RESYNC_EN
  // Re-align to the received word so a single slip costs exactly one error.
  assign expected_next = mismatch ? (tdata + DATA_ONE) : (expected + DATA_ONE);
`else
  assign expected_next = expected + DATA_ONE;
`endif

  // Throttle: LFSR free-runs out of reset, independent of any handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr   <= LFSR_SEED;
      tready <= 1'b0;
    end else begin
      lfsr   <= lfsr_next;
      tready <= !throttle_en || lfsr[0];
    end
  end

  // Expected value advances on every accept, including one coinciding with clear_stats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected <= '0;
    end else if (accept) begin
      expected <= expected_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count   <= '0;
      err_count    <= '0;
      err_sticky   <= 1'b0;
      tlast_err    <= 1'b0;
      err_expected <= '0;
      err_actual   <= '0;
    end else if (clear_stats) begin
      beat_count   <= '0;
      err_count    <= '0;
      err_sticky   <= 1'b0;
      tlast_err    <= 1'b0;
      err_expected <= '0;
      err_actual   <= '0;
    end else if (accept) begin
      if (beat_count != CNT_MAX) begin
        beat_count <= beat_count + CNT_ONE;
      end
      if (mismatch) begin
        if (err_count != CNT_MAX) begin
          err_count <= err_count + CNT_ONE;
        end
        // Only the first mismatch is captured until the next clear or reset.
        if (!err_sticky) begin
          err_sticky   <= 1'b1;
          err_expected <= expected;
          err_actual   <= tdata;
        end
      end
      if (!tlast) begin
        tlast_err <= 1'b1;
      end
    end
  end

endmodule
